// File: rtl/fwvip_wb_protocol_checker.sv
// Passive Wishbone protocol checker (classic or pipelined/STALL) with sticky status outputs.
// Define FWVIP_WB_PROTOCOL_CHECKER_ASSERT_EN to also raise an immediate assertion per check.
module fwvip_wb_protocol_checker #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int PIPELINED       = 0,
  parameter int MAX_CYCLE_LEN   = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [ADDR_WIDTH-1:0]                m_adr,
  input  logic [DATA_WIDTH-1:0]                m_dat_w,
  input  logic [DATA_WIDTH/8-1:0]              m_sel,
  input  logic                                 m_we,
  input  logic                                 m_cyc,
  input  logic                                 m_stb,
  input  logic                                 m_ack,
  input  logic                                 m_err,
  input  logic                                 m_stall,
  input  logic                                 clear,
  output logic [6:0]                           err_flags,
  output logic [ERR_CNT_WIDTH-1:0]             err_count,
  output logic                                 first_err_valid,
  output logic [2:0]                           first_err_code,
  output logic [$clog2(MAX_OUTSTANDING+1):0]   outstanding
);

  localparam int TMO_W = $clog2(MAX_CYCLE_LEN + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam int SEL_W = DATA_WIDTH / 8;

  logic                     stb_cyc, term, accept, active, progress, attr_diff, inc, dec;
  logic [6:0]               viol;
  logic                     pend_q, pend_d;
  logic                     hold_q, hold_d;
  logic [OUT_W-1:0]         outst_q, outst_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0]    cap_adr_q, cap_adr_d;
  logic [DATA_WIDTH-1:0]    cap_dat_q, cap_dat_d;
  logic [SEL_W-1:0]         cap_sel_q, cap_sel_d;
  logic                     cap_we_q, cap_we_d;
  logic [6:0]               flags_q, flags_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     fv_q, fv_d;
  logic [2:0]               fc_q, fc_d;

  function automatic logic [2:0] lowest_idx(input logic [6:0] v);
    lowest_idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  always_comb begin
    stb_cyc   = m_cyc & m_stb;
    term      = m_ack | m_err;
    accept    = stb_cyc & ~m_stall;
    attr_diff = (m_adr != cap_adr_q) | (m_we != cap_we_q) |
                (cap_we_q & ((m_sel != cap_sel_q) | (m_dat_w != cap_dat_q)));
    pend_d    = pend_q;
    hold_d    = hold_q;
    outst_d   = outst_q;
    cap_adr_d = cap_adr_q;
    cap_dat_d = cap_dat_q;
    cap_sel_d = cap_sel_q;
    cap_we_d  = cap_we_q;
    viol      = '0;
    active    = 1'b0;
    progress  = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;

    if (PIPELINED != 0) begin
      active   = (outst_q != '0) | stb_cyc;
      progress = term | accept;
      viol[2]  = ~m_cyc & (outst_q != '0);
      viol[3]  = hold_q & stb_cyc & attr_diff;
      viol[4]  = accept & (outst_q == OUT_W'(MAX_OUTSTANDING));
      viol[5]  = term & (outst_q == '0);
      inc      = accept & ~viol[4];
      // A term at zero only retires a request accepted in the same cycle.
      dec      = term & ((outst_q != '0) | inc);
      outst_d  = outst_q + OUT_W'(inc) - OUT_W'(dec);
      if (accept | ~stb_cyc) begin
        hold_d = 1'b0;
      end else if (!hold_q) begin
        hold_d    = 1'b1;
        cap_adr_d = m_adr;
        cap_dat_d = m_dat_w;
        cap_sel_d = m_sel;
        cap_we_d  = m_we;
      end
    end else begin
      active   = pend_q | stb_cyc;
      progress = term;
      viol[2]  = pend_q & ~term & ~stb_cyc;
      viol[3]  = pend_q & ~term & attr_diff;
      viol[5]  = term & ~stb_cyc;
      if (!pend_q && stb_cyc) begin
        cap_adr_d = m_adr;
        cap_dat_d = m_dat_w;
        cap_sel_d = m_sel;
        cap_we_d  = m_we;
      end
      pend_d = (pend_q | stb_cyc) & ~term;
    end

    viol[1] = m_stb & ~m_cyc;
    viol[6] = m_ack & m_err;

    // Counter saturates at the limit so the timeout flags once per episode.
    tmo_d = tmo_q;
    if (!active || progress) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_W'(MAX_CYCLE_LEN)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    viol[0] = active & ~progress & (tmo_q == TMO_W'(MAX_CYCLE_LEN - 1));

    flags_d = (clear ? 7'd0 : flags_q) | viol;
    cnt_d   = clear ? '0 : cnt_q;
    if ((|viol) && !(&cnt_d)) cnt_d = cnt_d + ERR_CNT_WIDTH'(1);
    fv_d = clear ? 1'b0 : fv_q;
    fc_d = clear ? 3'd0 : fc_q;
    if ((|viol) && !fv_d) begin
      fv_d = 1'b1;
      fc_d = lowest_idx(viol);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      hold_q    <= 1'b0;
      outst_q   <= '0;
      tmo_q     <= '0;
      cap_adr_q <= '0;
      cap_dat_q <= '0;
      cap_sel_q <= '0;
      cap_we_q  <= 1'b0;
      flags_q   <= '0;
      cnt_q     <= '0;
      fv_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      outst_q   <= outst_d;
      tmo_q     <= tmo_d;
      cap_adr_q <= cap_adr_d;
      cap_dat_q <= cap_dat_d;
      cap_sel_q <= cap_sel_d;
      cap_we_q  <= cap_we_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      fv_q      <= fv_d;
      fc_q      <= fc_d;
    end
  end

  assign err_flags       = flags_q;
  assign err_count       = cnt_q;
  assign first_err_valid = fv_q;
  assign first_err_code  = fc_q;
  assign outstanding     = (PIPELINED != 0) ? outst_q : OUT_W'(pend_q);

`ifdef FWVIP_WB_PROTOCOL_CHECKER_ASSERT_EN
  always @(posedge clock) begin
    if (!reset) begin
      a_timeout:  assert (!viol[0]) else $error("TIMEOUT m_adr=%h", m_adr);
      a_stb_cyc:  assert (!viol[1]) else $error("STB_NO_CYC m_adr=%h", m_adr);
      a_drop:     assert (!viol[2]) else $error("DROP m_adr=%h", m_adr);
      a_attr:     assert (!viol[3]) else $error("ATTR m_adr=%h", m_adr);
      a_overflow: assert (!viol[4]) else $error("OVERFLOW m_adr=%h", m_adr);
      a_spurious: assert (!viol[5]) else $error("SPURIOUS m_adr=%h", m_adr);
      a_ack_err:  assert (!viol[6]) else $error("ACK_ERR m_adr=%h", m_adr);
    end
  end
`endif

endmodule

// File: tb/tb_fwvip_wb_protocol_checker.sv
// Scoreboard bench: one classic and one pipelined checker watch the same random/directed link.
module tb_fwvip_wb_protocol_checker;
  localparam int L = 4;
  localparam int M = 2;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, ack, err, stall, clr;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [6:0]  c_flags, p_flags;
  logic [3:0]  c_cnt;
  logic [15:0] p_cnt;
  logic        c_fv, p_fv;
  logic [2:0]  c_fc, p_fc, c_out, p_out;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {int flags; int count; int fv; int fc; int outst;} exp_t;
  typedef struct {
    int pend; int outst; int hold; int idle;
    logic [31:0] cadr; logic [31:0] cdat; logic [3:0] csel; logic cwe;
    int flags; int count; int fv; int fc;
  } mdl_t;

  exp_t qc[$];
  exp_t qp[$];
  mdl_t mc, mp;

  always #5 clk = ~clk;

  fwvip_wb_protocol_checker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PIPELINED(0), .MAX_CYCLE_LEN(L),
                              .MAX_OUTSTANDING(M), .ERR_CNT_WIDTH(4)) u_classic (
    .clock(clk), .reset(rst), .m_adr(adr), .m_dat_w(dat), .m_sel(sel), .m_we(we),
    .m_cyc(cyc), .m_stb(stb), .m_ack(ack), .m_err(err), .m_stall(stall), .clear(clr),
    .err_flags(c_flags), .err_count(c_cnt), .first_err_valid(c_fv),
    .first_err_code(c_fc), .outstanding(c_out));

  fwvip_wb_protocol_checker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PIPELINED(1), .MAX_CYCLE_LEN(L),
                              .MAX_OUTSTANDING(M), .ERR_CNT_WIDTH(16)) u_pipe (
    .clock(clk), .reset(rst), .m_adr(adr), .m_dat_w(dat), .m_sel(sel), .m_we(we),
    .m_cyc(cyc), .m_stb(stb), .m_ack(ack), .m_err(err), .m_stall(stall), .clear(clr),
    .err_flags(p_flags), .err_count(p_cnt), .first_err_valid(p_fv),
    .first_err_code(p_fc), .outstanding(p_out));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit attr_changed(input mdl_t m);
    return (adr != m.cadr) || (we != m.cwe) || (m.cwe && ((sel != m.csel) || (dat != m.cdat)));
  endfunction

  function automatic void capture(inout mdl_t m);
    m.cadr = adr; m.cdat = dat; m.csel = sel; m.cwe = we;
  endfunction

  // Idle count equals the limit exactly once per progress-free episode.
  function automatic bit timeout_rule(inout mdl_t m, input bit act, input bit prog);
    if (act && !prog) begin
      m.idle++;
      return m.idle == L;
    end
    m.idle = 0;
    return 1'b0;
  endfunction

  function automatic logic [6:0] classic_step(inout mdl_t m);
    logic [6:0] v;
    bit sc, term;
    sc = cyc && stb;
    term = ack || err;
    v = '0;
    v[0] = timeout_rule(m, (m.pend != 0) || sc, term);
    v[1] = stb && !cyc;
    v[2] = (m.pend != 0) && !term && !sc;
    v[3] = (m.pend != 0) && !term && attr_changed(m);
    v[5] = term && !sc;
    v[6] = ack && err;
    if (m.pend == 0 && sc) capture(m);
    m.pend = ((m.pend != 0) || sc) && !term;
    return v;
  endfunction

  function automatic logic [6:0] pipe_step(inout mdl_t m);
    logic [6:0] v;
    bit sc, term, acc;
    int n;
    sc = cyc && stb;
    term = ack || err;
    acc = sc && !stall;
    v = '0;
    v[0] = timeout_rule(m, (m.outst > 0) || sc, term || acc);
    v[1] = stb && !cyc;
    v[2] = !cyc && (m.outst > 0);
    v[3] = (m.hold != 0) && sc && attr_changed(m);
    v[4] = acc && (m.outst == M);
    v[5] = term && (m.outst == 0);
    v[6] = ack && err;
    n = m.outst + ((acc && m.outst < M) ? 1 : 0) - (term ? 1 : 0);
    m.outst = (n < 0) ? 0 : n;
    if (acc || !sc) m.hold = 0;
    else if (m.hold == 0) begin
      capture(m);
      m.hold = 1;
    end
    return v;
  endfunction

  function automatic void status_upd(inout mdl_t m, input logic [6:0] v, input int cmax);
    if (clr) begin
      m.flags = 0; m.count = 0; m.fv = 0; m.fc = 0;
    end
    if (v != 0) begin
      m.flags = m.flags | int'(v);
      if (m.count < cmax) m.count++;
      if (m.fv == 0) begin
        m.fv = 1;
        for (int i = 0; i < 7; i++) begin
          if (v[i]) begin
            m.fc = i;
            break;
          end
        end
      end
    end
  endfunction

  // Apply current inputs to the models, queue expectations, advance to next negedge.
  task automatic step();
    logic [6:0] v;
    if (rst) begin
      mc = '{default: 0};
      mp = '{default: 0};
    end else begin
      v = classic_step(mc);
      status_upd(mc, v, 15);
      v = pipe_step(mp);
      status_upd(mp, v, 65535);
    end
    qc.push_back('{mc.flags, mc.count, mc.fv, mc.fc, mc.pend});
    qp.push_back('{mp.flags, mp.count, mp.fv, mp.fc, mp.outst});
    @(negedge clk);
  endtask

  task automatic set_idle();
    cyc = 0; stb = 0; we = 0; ack = 0; err = 0; stall = 0; clr = 0;
    adr = '0; dat = '0; sel = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qc.size() == 0 || qp.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        e = qc.pop_front();
        chk("c_flags", c_flags, e.flags);
        chk("c_count", c_cnt, e.count);
        chk("c_fvalid", c_fv, e.fv);
        chk("c_fcode", c_fc, e.fc);
        chk("c_outstanding", c_out, e.outst);
        e = qp.pop_front();
        chk("p_flags", p_flags, e.flags);
        chk("p_count", p_cnt, e.count);
        chk("p_fvalid", p_fv, e.fv);
        chk("p_fcode", p_fc, e.fc);
        chk("p_outstanding", p_out, e.outst);
      end
    end
  end

  initial begin
    set_idle();
    rst = 1;
    step();
    step();
    rst = 0;
    chk("rst_c_flags", c_flags, 0);
    chk("rst_c_count", c_cnt, 0);
    chk("rst_p_outstanding", p_out, 0);

    // classic timeout, then a proper ack
    cyc = 1; stb = 1; adr = 32'h100;
    step();
    chk("c_pending_set", c_out, 1);
    repeat (5) step();
    ack = 1; step();
    set_idle(); step();
    chk("tmo_flags", c_flags, 7'h01);
    chk("tmo_code", c_fc, 0);
    chk("tmo_count", c_cnt, 1);

    // classic write data change before ack
    do_reset();
    cyc = 1; stb = 1; we = 1; adr = 32'h100; sel = 4'hF; dat = 32'hA5;
    step();
    dat = 32'h5A; step();
    ack = 1; step();
    set_idle(); step();
    chk("attr_we1", c_flags[3], 1);
    do_reset();
    cyc = 1; stb = 1; we = 0; adr = 32'h100; sel = 4'hF; dat = 32'hA5;
    step();
    dat = 32'h5A; step();
    ack = 1; step();
    set_idle(); step();
    chk("attr_we0_flags", c_flags, 0);

    // strobe without cycle, then clear together with another violation
    do_reset();
    stb = 1;
    repeat (3) step();
    chk("stbnc_flags", c_flags, 7'h02);
    chk("stbnc_count", c_cnt, 3);
    chk("stbnc_code", c_fc, 1);
    clr = 1; step(); clr = 0;
    chk("clr_count", c_cnt, 1);
    chk("clr_code", c_fc, 1);
    chk("clr_valid", c_fv, 1);
    set_idle(); step();

    // pipelined overflow then drain
    do_reset();
    cyc = 1; stb = 1;
    repeat (3) step();
    chk("ovf_outstanding", p_out, 2);
    chk("ovf_flag", p_flags[4], 1);
    stb = 0; ack = 1;
    repeat (2) step();
    chk("drain_outstanding", p_out, 0);
    chk("drain_no_spurious", p_flags[5], 0);
    set_idle(); step();

    // pipelined spurious, alone and with err
    do_reset();
    cyc = 1; ack = 1; step();
    chk("spur_flags", p_flags, 7'h20);
    do_reset();
    cyc = 1; ack = 1; err = 1; step();
    chk("ackerr_flags", p_flags, 7'h60);
    chk("ackerr_count", p_cnt, 1);
    chk("ackerr_code", p_fc, 5);
    set_idle(); step();

    // reset mid-transfer, then a clean transfer
    do_reset();
    cyc = 1; stb = 1; step();
    stb = 0; step();
    chk("mid_outstanding", p_out, 1);
    set_idle(); rst = 1; step(); rst = 0;
    chk("midrst_flags", p_flags, 0);
    chk("midrst_count", p_cnt, 0);
    chk("midrst_valid", p_fv, 0);
    chk("midrst_outstanding", p_out, 0);
    cyc = 1; stb = 1; adr = 32'h200; step();
    stb = 0; ack = 1; step();
    set_idle(); step();
    chk("clean_flags", p_flags, 0);
    chk("clean_outstanding", p_out, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 249) == 0);
      clr   = ($urandom_range(0, 29) == 0);
      cyc   = ($urandom_range(0, 3) != 0);
      stb   = ($urandom_range(0, 2) != 0);
      ack   = ($urandom_range(0, 3) == 0);
      err   = ($urandom_range(0, 9) == 0);
      stall = $urandom_range(0, 1);
      we    = $urandom_range(0, 1);
      adr   = 32'h100 + 32'($urandom_range(0, 1) * 4);
      dat   = $urandom_range(0, 1) ? 32'hA5 : 32'h5A;
      sel   = ($urandom_range(0, 3) == 0) ? 4'h3 : 4'hF;
      step();
    end
    rst = 0;
    set_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
